axi4_lite_master: RTL and testbench

Command-driven AXI4-Lite initiator, the master-side counterpart of axi4_lite_slave, used by test/bring-up logic and small controllers to access register blocks.
- Accepts one read or write command on a valid/ready port.
- Runs exactly one AXI4-Lite transaction at a time.
- Returns the read data and response on a valid/ready response port.

---
 rtl/axi4_lite_master_pkg.sv | 40 ++++
 rtl/axi4_lite_master.sv | 204 ++++++++++++++++++++
 tb/tb_axi4_lite_master.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_master_pkg.sv
// Shared AXI4-Lite definitions: response codes, master FSM states and the
// command/response records latched by axi4_lite_master.
package axi4_lite_master_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Record widths; the master casts its port widths onto these fields.
    localparam int AXIL_ADDR_W = 32;
    localparam int AXIL_DATA_W = 32;
    localparam int AXIL_STRB_W = AXIL_DATA_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_REQ   = 3'd1,
        ST_WR_RESP  = 3'd2,
        ST_RD_REQ   = 3'd3,
        ST_RD_RESP  = 3'd4,
        ST_RSP_HOLD = 3'd5
    } axil_mst_state_e;

    typedef struct packed {
        logic                   write;
        logic [AXIL_ADDR_W-1:0] addr;
        logic [AXIL_DATA_W-1:0] wdata;
        logic [AXIL_STRB_W-1:0] wstrb;
    } axil_cmd_t;

    typedef struct packed {
        logic                   write;
        logic [AXIL_DATA_W-1:0] rdata;
        logic [1:0]             resp;
    } axil_rsp_t;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi4_lite_master.sv
// Command-driven AXI4-Lite initiator, one transaction in flight at a time.
// Optional error counter output enabled by AXI4_LITE_MASTER_ERR_CNT_EN.
//
// state       | meaning
// IDLE        | cmd_ready high, waiting for a command
// WR_REQ      | AW and W offered, each drops after its own handshake
// WR_RESP     | bready high, waiting for B
// RD_REQ      | AR offered until arready
// RD_RESP     | rready high, waiting for R
// RSP_HOLD    | rsp_valid high with stable payload until rsp_ready
module axi4_lite_master
    import axi4_lite_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,

    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [STRB_WIDTH-1:0] wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
`ifdef AXI4_LITE_MASTER_ERR_CNT_EN
    output logic [15:0]           err_count,
`endif
    output logic                  rready
);

    axil_mst_state_e r_state;
    axil_mst_state_e w_state_nxt;

    axil_cmd_t r_cmd;
    axil_rsp_t r_rsp;
    logic      r_cmd_ready;
    logic      r_awvalid;
    logic      r_wvalid;
    logic      r_arvalid;

    logic w_cmd_fire;
    logic w_aw_fire;
    logic w_w_fire;
    logic w_ar_fire;
    logic w_b_fire;
    logic w_r_fire;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_fire  = 1'b0;
        w_aw_fire   = 1'b0;
        w_w_fire    = 1'b0;
        w_ar_fire   = 1'b0;
        w_b_fire    = 1'b0;
        w_r_fire    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_cmd_fire  = 1'b1;
                    w_state_nxt = cmd_write ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                w_aw_fire = r_awvalid && awready;
                w_w_fire  = r_wvalid && wready;
                // Both channels done, counting a handshake landing this cycle.
                if ((!r_awvalid || awready) && (!r_wvalid || wready)) begin
                    w_state_nxt = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (bvalid) begin
                    w_b_fire    = 1'b1;
                    w_state_nxt = ST_RSP_HOLD;
                end
            end
            ST_RD_REQ: begin
                if (r_arvalid && arready) begin
                    w_ar_fire   = 1'b1;
                    w_state_nxt = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                if (rvalid) begin
                    w_r_fire    = 1'b1;
                    w_state_nxt = ST_RSP_HOLD;
                end
            end
            ST_RSP_HOLD: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_cmd       <= '0;
            r_rsp       <= '0;
            r_cmd_ready <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_arvalid   <= 1'b0;
        end else begin
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            if (w_cmd_fire) begin
                r_cmd.write <= cmd_write;
                r_cmd.addr  <= AXIL_ADDR_W'(cmd_addr);
                r_cmd.wdata <= AXIL_DATA_W'(cmd_wdata);
                r_cmd.wstrb <= AXIL_STRB_W'(cmd_wstrb);
                r_awvalid   <= cmd_write;
                r_wvalid    <= cmd_write;
                r_arvalid   <= !cmd_write;
            end
            if (w_aw_fire) begin
                r_awvalid <= 1'b0;
            end
            if (w_w_fire) begin
                r_wvalid <= 1'b0;
            end
            if (w_ar_fire) begin
                r_arvalid <= 1'b0;
            end
            if (w_b_fire) begin
                r_rsp.write <= r_cmd.write;
                r_rsp.rdata <= '0;
                r_rsp.resp  <= bresp;
            end
            if (w_r_fire) begin
                r_rsp.write <= r_cmd.write;
                r_rsp.rdata <= AXIL_DATA_W'(rdata);
                r_rsp.resp  <= rresp;
            end
        end
    end

`ifdef AXI4_LITE_MASTER_ERR_CNT_EN
    logic [15:0] r_err_count;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_err_count <= '0;
        end else if (((w_b_fire && resp_is_err(bresp)) || (w_r_fire && resp_is_err(rresp)))
                     && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign err_count = r_err_count;
`endif

    assign cmd_ready = r_cmd_ready;

    assign awaddr  = ADDR_WIDTH'(r_cmd.addr);
    assign awvalid = r_awvalid;
    assign wdata   = DATA_WIDTH'(r_cmd.wdata);
    assign wstrb   = STRB_WIDTH'(r_cmd.wstrb);
    assign wvalid  = r_wvalid;
    assign araddr  = ADDR_WIDTH'(r_cmd.addr);
    assign arvalid = r_arvalid;
    assign bready  = (r_state == ST_WR_RESP);
    assign rready  = (r_state == ST_RD_RESP);

    assign rsp_valid = (r_state == ST_RSP_HOLD);
    assign rsp_write = r_rsp.write;
    assign rsp_rdata = DATA_WIDTH'(r_rsp.rdata);
    assign rsp_resp  = r_rsp.resp;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master against a small behavioural register
// slave with programmable AW/W stall depth and injectable stray B/R valids.
module tb_axi4_lite_master;
    import axi4_lite_master_pkg::*;

    localparam logic [31:0] IP_VERSION = 32'h0102_0003;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
`ifdef AXI4_LITE_MASTER_ERR_CNT_EN
    logic [15:0] err_count;
`endif

    axi4_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
`ifdef AXI4_LITE_MASTER_ERR_CNT_EN
        .err_count(err_count),
`endif
        .rready(rready)
    );

    // ---------------- behavioural slave ----------------
    int          aw_wait = 0, w_wait = 0;
    int          aw_cnt, w_cnt;
    logic        aw_got, w_got, s_bvalid, s_rvalid;
    logic        spur_b = 1'b0, spur_r = 1'b0;
    logic [31:0] s_awaddr, s_wdata, s_rdata, scratch;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp, s_rresp;
    logic        aw_ok, w_ok;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;

    assign awready = awvalid && (aw_cnt >= aw_wait);
    assign wready  = wvalid && (w_cnt >= w_wait);
    assign arready = arvalid;
    assign bvalid  = s_bvalid | spur_b;
    assign bresp   = s_bresp;
    assign rvalid  = s_rvalid | spur_r;
    assign rdata   = s_rdata;
    assign rresp   = s_rresp;

    assign aw_ok   = aw_got || (awvalid && awready);
    assign w_ok    = w_got || (wvalid && wready);
    assign wr_addr = aw_got ? s_awaddr : awaddr;
    assign wr_data = w_got ? s_wdata : wdata;
    assign wr_strb = w_got ? s_wstrb : wstrb;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        return m;
    endfunction

    always @(posedge aclk) begin
        if (!aresetn) begin
            aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_bresp <= 2'b00; s_rresp <= 2'b00;
            s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0; s_rdata <= '0; scratch <= '0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            if (awvalid && awready) begin aw_got <= 1'b1; s_awaddr <= awaddr; end
            if (wvalid && wready) begin w_got <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb; end
            if (s_bvalid && bready) s_bvalid <= 1'b0;
            if (aw_ok && w_ok && !s_bvalid) begin
                aw_got <= 1'b0; w_got <= 1'b0; s_bvalid <= 1'b1;
                s_bresp <= (wr_addr == 32'h40) ? RESP_SLVERR : RESP_OKAY;
                if (wr_addr == 32'h18) scratch <= merge(scratch, wr_data, wr_strb);
            end
            if (s_rvalid && rready) s_rvalid <= 1'b0;
            if (arvalid && arready) begin
                s_rvalid <= 1'b1;
                case (araddr)
                    32'h18:  begin s_rdata <= scratch;      s_rresp <= RESP_OKAY;   end
                    32'h1C:  begin s_rdata <= IP_VERSION;   s_rresp <= RESP_OKAY;   end
                    32'h40:  begin s_rdata <= 32'hDEADBEEF; s_rresp <= RESP_SLVERR; end
                    default: begin s_rdata <= '0;           s_rresp <= RESP_DECERR; end
                endcase
            end
        end
    end

    // ---------------- bus monitors ----------------
    logic        mon_clr = 1'b0;
    int          b_hs, aw_cyc, w_cyc, act_cyc;
    logic        w_unstable, w_prev_v;
    logic [31:0] w_prev;

    always @(posedge aclk) begin
        if (mon_clr) begin
            b_hs <= 0; aw_cyc <= 0; w_cyc <= 0; act_cyc <= 0;
            w_unstable <= 1'b0; w_prev_v <= 1'b0; w_prev <= '0;
        end else begin
            if (bvalid && bready) b_hs <= b_hs + 1;
            if (awvalid) aw_cyc <= aw_cyc + 1;
            if (wvalid) w_cyc <= w_cyc + 1;
            if (awvalid || wvalid || arvalid || bready || rready) act_cyc <= act_cyc + 1;
            if (w_prev_v && wvalid && (wdata !== w_prev)) w_unstable <= 1'b1;
            w_prev_v <= wvalid && !wready;
            w_prev   <= wdata;
        end
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Presents a command; returns at the negedge of cycle 1 (cycle 0 = accept).
    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] st);
        int n = 0;
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st;
        while (!cmd_ready && n < 100) begin @(negedge aclk); n++; end
        chk("cmd_accept_in_time", n < 100, 1'b1);
        @(negedge aclk);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic w, output logic [31:0] d, output logic [1:0] r,
                           output int lat);
        lat = 1;
        while (!rsp_valid && lat < 100) begin @(negedge aclk); lat++; end
        chk("rsp_in_time", lat < 100, 1'b1);
        w = rsp_write; d = rsp_rdata; r = rsp_resp;
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
    endtask

    task automatic xact(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] st,
                        input logic [31:0] exp_d, input logic [1:0] exp_r);
        logic        w;
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        send_cmd(wr, addr, wd, st);
        get_rsp(w, d, r, lat);
        chk({tag, "_write"}, w, wr);
        chk({tag, "_rdata"}, d, exp_d);
        chk({tag, "_resp"}, r, exp_r);
        chk({tag, "_latency"}, lat, 3);
    endtask

    logic        t_w;
    logic [31:0] t_d;
    logic [1:0]  t_r;
    int          t_lat;

    initial begin
        // reset state
        mon_clr = 1'b1;
        repeat (3) @(negedge aclk);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_valids", {awvalid, wvalid, arvalid, rsp_valid}, 4'b0000);
        chk("rst_readies", {bready, rready}, 2'b00);
        chk("rst_payload", {awaddr, wdata}, 64'h0);
        aresetn = 1'b1;
        mon_clr = 1'b0;
        @(negedge aclk);
        chk("post_rst_cmd_ready", cmd_ready, 1'b1);

        // basic write / read-back, partial strobe
        xact("wr_scratch", 1'b1, 32'h18, 32'hA5A5_0001, 4'hF, 32'h0, RESP_OKAY);
        xact("rd_scratch", 1'b0, 32'h18, 32'h0, 4'h0, 32'hA5A5_0001, RESP_OKAY);
        xact("wr_strb", 1'b1, 32'h18, 32'h1122_3344, 4'h3, 32'h0, RESP_OKAY);
        xact("rd_strb", 1'b0, 32'h18, 32'h0, 4'h0, 32'hA5A5_3344, RESP_OKAY);

        // version read with a queued second command and a 5-cycle rsp_ready stall
        send_cmd(1'b0, 32'h1C, 32'h0, 4'h0);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h18;
        cmd_wdata = 32'h5A5A_0002; cmd_wstrb = 4'hF;
        chk("b2b_ready_c1", cmd_ready, 1'b0);
        @(negedge aclk);
        chk("b2b_ready_c2", cmd_ready, 1'b0);
        @(negedge aclk);
        chk("b2b_rsp_valid_c3", rsp_valid, 1'b1);
        mon_clr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_rsp_valid", rsp_valid, 1'b1);
            chk("hold_rsp_payload", {rsp_write, rsp_resp, rsp_rdata}, {1'b0, RESP_OKAY, IP_VERSION});
            chk("hold_cmd_ready", cmd_ready, 1'b0);
            @(negedge aclk);
            mon_clr = 1'b0;
        end
        chk("hold_no_axi_activity", act_cyc, 0);
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
        chk("hold_rsp_valid_drop", rsp_valid, 1'b0);
        chk("b2b_cmd_ready_back", cmd_ready, 1'b1);
        @(negedge aclk);
        cmd_valid = 1'b0;
        get_rsp(t_w, t_d, t_r, t_lat);
        chk("b2b_wr_resp", {t_w, t_r, t_d}, {1'b1, RESP_OKAY, 32'h0});
        chk("b2b_wr_latency", t_lat, 3);
        xact("rd_b2b", 1'b0, 32'h18, 32'h0, 4'h0, 32'h5A5A_0002, RESP_OKAY);

        // error responses pass through
        xact("rd_err", 1'b0, 32'h40, 32'h0, 4'h0, 32'hDEAD_BEEF, RESP_SLVERR);
        xact("wr_err", 1'b1, 32'h40, 32'h1234_5678, 4'hF, 32'h0, RESP_SLVERR);
        xact("rd_decerr", 1'b0, 32'h80, 32'h0, 4'h0, 32'h0, RESP_DECERR);
`ifdef AXI4_LITE_MASTER_ERR_CNT_EN
        chk("err_count_3", err_count, 16'd3);
`endif

        // stray B/R valids while idle are not accepted
        @(negedge aclk);
        spur_b = 1'b1; spur_r = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            chk("stray_readies", {bready, rready, cmd_ready}, 3'b001);
        end
        spur_b = 1'b0; spur_r = 1'b0;
        xact("after_stray", 1'b0, 32'h1C, 32'h0, 4'h0, IP_VERSION, RESP_OKAY);

        // W stalled 3 cycles, AW immediate
        mon_clr = 1'b1;
        @(negedge aclk);
        mon_clr = 1'b0; aw_wait = 0; w_wait = 3;
        send_cmd(1'b1, 32'h18, 32'h1357_2468, 4'hF);
        chk("wstall_c1_valids", {awvalid, wvalid}, 2'b11);
        @(negedge aclk);
        chk("wstall_c2_valids", {awvalid, wvalid}, 2'b01);
        get_rsp(t_w, t_d, t_r, t_lat);
        chk("wstall_resp", {t_w, t_r}, {1'b1, RESP_OKAY});
        chk("wstall_aw_cycles", aw_cyc, 1);
        chk("wstall_w_cycles", w_cyc, 4);
        chk("wstall_b_count", b_hs, 1);
        chk("wstall_wdata_stable", w_unstable, 1'b0);

        // AW stalled 3 cycles, W immediate
        mon_clr = 1'b1;
        @(negedge aclk);
        mon_clr = 1'b0; aw_wait = 3; w_wait = 0;
        send_cmd(1'b1, 32'h18, 32'h2468_1357, 4'hF);
        get_rsp(t_w, t_d, t_r, t_lat);
        chk("awstall_resp", {t_w, t_r}, {1'b1, RESP_OKAY});
        chk("awstall_aw_cycles", aw_cyc, 4);
        chk("awstall_w_cycles", w_cyc, 1);
        chk("awstall_b_count", b_hs, 1);
        aw_wait = 0;
        xact("rd_awstall", 1'b0, 32'h18, 32'h0, 4'h0, 32'h2468_1357, RESP_OKAY);

        // reset while AW/W are pending
        aw_wait = 3; w_wait = 3;
        send_cmd(1'b1, 32'h18, 32'h0BAD_0BAD, 4'hF);
        chk("mid_rst_pending", {awvalid, wvalid}, 2'b11);
        aresetn = 1'b0;
        @(negedge aclk);
        chk("mid_rst_valids", {awvalid, wvalid, arvalid, rsp_valid}, 4'b0000);
        chk("mid_rst_readies", {bready, rready, cmd_ready}, 3'b000);
`ifdef AXI4_LITE_MASTER_ERR_CNT_EN
        chk("mid_rst_err_count", err_count, 16'd0);
`endif
        aresetn = 1'b1; aw_wait = 0; w_wait = 0;
        @(negedge aclk);
        chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
        xact("rd_after_rst", 1'b0, 32'h18, 32'h0, 4'h0, 32'h0, RESP_OKAY);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
